// File: rtl/ldarb_pkg.sv
// Shared defaults and FSM state encoding for the load-register write arbiter.
package ldarb_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned AW_DEF    = 3;
  localparam int unsigned DW_DEF    = 32;

  // IDLE: no grant issued this cycle; ISSUE: a grant is on the outputs this cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/loadreg_write_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan priorities ptr, ptr+1, ... and take the first requester found
  always_comb begin
    int unsigned pos;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!any && req[j] && (j == pos)) begin
          pick[j] = 1'b1;
          idx     = IW'(j);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/loadreg_write_arbiter.sv
// Round-robin write arbiter sharing one load-register bank between N requesters.
module loadreg_write_arbiter
  import ldarb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*AW-1:0]   addr,
  input  logic [N*DW-1:0]   data,
  output logic [N-1:0]      gnt,
  output logic [DEPTH-1:0]  ld_en,
  output logic [DW-1:0]     ld_data,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t          state, next_state;
  logic [IW-1:0]       ptr;
  logic [N-1:0]        gnt_q;
  logic [DEPTH-1:0]    ld_en_q;
  logic [DW-1:0]       ld_data_q;
  logic                err_q;

  logic [N-1:0]        req_masked;
  logic [N-1:0]        pick;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_data;
  logic [DEPTH-1:0]    dec_en;
  logic                dec_err;

  // The requester being granted this cycle may still hold req; keep it out of this round
  assign req_masked = req & ~gnt;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req  (req_masked),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // One-hot mux of the winner's address and data
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_addr = sel_addr | (addr[i*AW +: AW] & {AW{pick[i]}});
      sel_data = sel_data | (data[i*DW +: DW] & {DW{pick[i]}});
    end
  end

  // Address decode; addresses beyond the bank raise err instead of a load enable
  always_comb begin
    dec_err = !(32'(sel_addr) < DEPTH);
    dec_en  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      dec_en[k] = (32'(sel_addr) == k);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state: issue whenever an unmasked request is pending
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = pick_any ? ISSUE : IDLE;
      ISSUE:   next_state = pick_any ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered grant, decode, data and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      gnt_q     <= '0;
      ld_en_q   <= '0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
    end else begin
      gnt_q   <= pick_any ? pick : '0;
      ld_en_q <= (pick_any && !dec_err) ? dec_en : '0;
      err_q   <= pick_any && dec_err;
      if (pick_any) begin
        ld_data_q <= sel_data;
        ptr       <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // FSM outputs: strobes only in ISSUE; busy is forced low while reset is asserted
  always_comb begin
    gnt     = (state == ISSUE) ? gnt_q   : '0;
    ld_en   = (state == ISSUE) ? ld_en_q : '0;
    err     = (state == ISSUE) ? err_q   : 1'b0;
    ld_data = ld_data_q;
    busy    = rst_n && ((|req) || (state == ISSUE));
  end

endmodule
